// File: rtl/note_tone_synth.sv
// Note player: takes {note code, beats} over valid/ready, plays a square wave
// on spk1 for the note length minus a trailing silent gap, and holds one
// pending note so the sequencer can queue ahead.
module note_tone_synth #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned BEAT_CYCLES = 16666660,
  parameter int unsigned GAP_CYCLES  = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [3:0] note_code,
  input  logic [3:0] note_beats,
  output logic       spk1,
  output logic       busy,
  output logic       note_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TONE,
    S_GAP
  } state_e;

  // Octave-4 half periods in clk cycles; octave 5 is derived by halving.
  localparam logic [16:0] HP_C4 = 17'(CLK_HZ / 261 / 2);
  localparam logic [16:0] HP_D4 = 17'(CLK_HZ / 293 / 2);
  localparam logic [16:0] HP_E4 = 17'(CLK_HZ / 329 / 2);
  localparam logic [16:0] HP_F4 = 17'(CLK_HZ / 349 / 2);
  localparam logic [16:0] HP_G4 = 17'(CLK_HZ / 392 / 2);
  localparam logic [16:0] HP_A4 = 17'(CLK_HZ / 440 / 2);
  localparam logic [16:0] HP_B4 = 17'(CLK_HZ / 493 / 2);

  localparam logic [31:0] BEAT_W = 32'(BEAT_CYCLES);
  localparam logic [31:0] GAP_W  = 32'(GAP_CYCLES);

  function automatic logic [16:0] hp_lookup(input logic [3:0] code);
    logic [16:0] hp4;
    case (code)
      4'd1, 4'd8:  hp4 = HP_C4;
      4'd2, 4'd9:  hp4 = HP_D4;
      4'd3, 4'd10: hp4 = HP_E4;
      4'd4, 4'd11: hp4 = HP_F4;
      4'd5, 4'd12: hp4 = HP_G4;
      4'd6, 4'd13: hp4 = HP_A4;
      4'd7, 4'd14: hp4 = HP_B4;
      default:     hp4 = '0;
    endcase
    return (code >= 4'd8) ? (hp4 >> 1) : hp4;
  endfunction

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [3:0]  pend_code_q, pend_code_d;
  logic [3:0]  pend_beats_q, pend_beats_d;
  logic [16:0] hp_cnt_q, hp_cnt_d;
  logic [16:0] hp_reload_q, hp_reload_d;
  logic        rest_q, rest_d;
  logic [31:0] phase_cnt_q, phase_cnt_d;
  logic        spk_q, spk_d;

  logic        accept;
  logic        take_pend;
  logic [16:0] pend_hp;
  logic        pend_rest;

  assign note_ready = rst_n & ~pend_valid_q;
  assign accept     = note_valid & note_ready;
  assign busy       = (state_q != S_IDLE) | pend_valid_q;
  assign spk1       = spk_q;
  assign pend_hp    = hp_lookup(pend_code_q);
  assign pend_rest  = (pend_code_q == 4'd0) | (pend_code_q == 4'd15);

  // Register all state; synchronous active-low reset aborts any note.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      pend_beats_q <= '0;
      hp_cnt_q     <= '0;
      hp_reload_q  <= '0;
      rest_q       <= 1'b0;
      phase_cnt_q  <= '0;
      spk_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      pend_beats_q <= pend_beats_d;
      hp_cnt_q     <= hp_cnt_d;
      hp_reload_q  <= hp_reload_d;
      rest_q       <= rest_d;
      phase_cnt_q  <= phase_cnt_d;
      spk_q        <= spk_d;
    end
  end

  // Next-state: tone/gap sequencing, pending-slot consume and accept.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    pend_beats_d = pend_beats_q;
    hp_cnt_d     = hp_cnt_q;
    hp_reload_d  = hp_reload_q;
    rest_d       = rest_q;
    phase_cnt_d  = phase_cnt_q;
    spk_d        = spk_q;
    note_done    = 1'b0;
    take_pend    = 1'b0;

    case (state_q)
      S_IDLE: begin
        take_pend = pend_valid_q;
      end
      S_TONE: begin
        if (!rest_q) begin
          if (hp_cnt_q == '0) begin
            spk_d    = ~spk_q;
            hp_cnt_d = hp_reload_q - 17'd1;
          end else begin
            hp_cnt_d = hp_cnt_q - 17'd1;
          end
        end
        if (phase_cnt_q == '0) begin
          state_d     = S_GAP;
          phase_cnt_d = GAP_W - 32'd1;
          spk_d       = 1'b0;
        end else begin
          phase_cnt_d = phase_cnt_q - 32'd1;
        end
      end
      S_GAP: begin
        spk_d = 1'b0;
        if (phase_cnt_q == '0) begin
          note_done = 1'b1;
          state_d   = S_IDLE;
          take_pend = pend_valid_q;
        end else begin
          phase_cnt_d = phase_cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Slot consume is shared by IDLE and end-of-gap so back-to-back notes
    // start with no IDLE cycle; a zero-beat note is simply dropped.
    if (take_pend) begin
      pend_valid_d = 1'b0;
      if (pend_beats_q != '0) begin
        state_d     = S_TONE;
        rest_d      = pend_rest;
        hp_reload_d = pend_hp;
        hp_cnt_d    = pend_rest ? '0 : (pend_hp - 17'd1);
        phase_cnt_d = ({28'd0, pend_beats_q} * BEAT_W) - GAP_W - 32'd1;
        spk_d       = 1'b0;
      end
    end

    if (accept) begin
      pend_valid_d = 1'b1;
      pend_code_d  = note_code;
      pend_beats_d = note_beats;
    end
  end

endmodule

// File: tb/tb_note_tone_synth.sv
// Bench for note_tone_synth: per-cycle comparison of spk1/note_done/busy/
// note_ready against a time-based note schedule model, plus scenario checks.
module tb_note_tone_synth;

  localparam int unsigned CLK_HZ = 200000;
  localparam int unsigned BEAT   = 2000;
  localparam int unsigned GAP    = 200;
  localparam int unsigned LIMIT  = 20000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       note_valid;
  logic       note_ready;
  logic [3:0] note_code;
  logic [3:0] note_beats;
  logic       spk1;
  logic       busy;
  logic       note_done;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  longint unsigned cyc = 0;

  // Schedule model: the playing note occupies [m_start, m_start+m_len).
  bit              m_active = 1'b0;
  bit              m_pend   = 1'b0;
  bit              m_acc    = 1'b0;
  bit              m_rest   = 1'b0;
  longint unsigned m_start  = 0;
  longint unsigned m_len    = 0;
  longint unsigned m_hp     = 1;
  logic [3:0]      m_pcode  = '0;
  logic [3:0]      m_pbeats = '0;

  note_tone_synth #(
    .CLK_HZ(CLK_HZ),
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .note_code(note_code),
    .note_beats(note_beats),
    .spk1(spk1),
    .busy(busy),
    .note_done(note_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic int unsigned hp_ref(input logic [3:0] c);
    int unsigned f;
    int unsigned h;
    case ((int'(c) - 1) % 7)
      0: f = 261;
      1: f = 293;
      2: f = 329;
      3: f = 349;
      4: f = 392;
      5: f = 440;
      default: f = 493;
    endcase
    h = CLK_HZ / f / 2;
    if (c >= 4'd8) h = h / 2;
    return h;
  endfunction

  // Expected {spk1, note_done, busy, note_ready} after the current edge.
  function automatic logic [3:0] exp_outs();
    logic s = 1'b0;
    logic d = 1'b0;
    longint unsigned off;
    if (m_active) begin
      off = cyc - m_start;
      s = !m_rest && (off < m_len - GAP) && ((off / m_hp) % 2 == 1);
      d = (cyc == m_start + m_len - 1);
    end
    return {s, d, (m_active || m_pend), (rst_n && !m_pend)};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    m_acc = rst_n && note_valid && !m_pend;
    if (!rst_n) begin
      m_active = 1'b0;
      m_pend   = 1'b0;
    end else begin
      if (m_active && cyc >= m_start + m_len) m_active = 1'b0;
      if (!m_active && m_pend) begin
        m_pend = 1'b0;
        if (m_pbeats != 4'd0) begin
          m_active = 1'b1;
          m_start  = cyc;
          m_len    = longint'(m_pbeats) * BEAT;
          m_rest   = (m_pcode == 4'd0) || (m_pcode == 4'd15);
          m_hp     = m_rest ? 1 : hp_ref(m_pcode);
        end
      end
      if (m_acc) begin
        m_pend   = 1'b1;
        m_pcode  = note_code;
        m_pbeats = note_beats;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; note_valid = 1'b1; note_code = 4'd6; note_beats = 4'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({spk1, note_done, busy, note_ready} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=0000", cyc, {spk1, note_done, busy, note_ready});
      end
    end
    note_valid = 1'b0; rst_n = 1'b1; #1;
    n_cmp++;
    if ({spk1, note_done, busy, note_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_release got=%b want=0001", {spk1, note_done, busy, note_ready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({spk1, note_done, busy, note_ready} !== exp_outs()) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, {spk1, note_done, busy, note_ready}, exp_outs());
      end
    end
  endtask

  task automatic test_single_a4();
    longint unsigned t_acc = 0;
    longint unsigned t_done = 0;
    int unsigned tog = 0;
    int unsigned tog_ref = 0;
    logic prev;
    bit ok = 1'b0;
    prev = spk1;
    note_valid = 1'b1; note_code = 4'd6; note_beats = 4'd1;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      n_cmp++;
      if ({spk1, note_done, busy, note_ready} !== exp_outs()) begin
        n_bad++;
        $display("FAIL single_cycle cyc=%0d got=%b want=%b", cyc, {spk1, note_done, busy, note_ready}, exp_outs());
      end
      if (m_acc) begin t_acc = cyc; note_valid = 1'b0; end
      if (t_acc != 0 && cyc <= t_acc + BEAT - GAP && spk1 !== prev) tog++;
      prev = spk1;
      if (note_done === 1'b1) t_done = cyc;
      if (t_acc != 0 && !m_active && !m_pend) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL single_timeout cyc=%0d", cyc); end
    for (int k = 1; k * hp_ref(4'd6) < BEAT - GAP; k++) tog_ref++;
    n_cmp++;
    if (tog != tog_ref) begin
      n_bad++; $display("FAIL single_toggles got=%0d want=%0d", tog, tog_ref);
    end
    n_cmp++;
    if (t_done != t_acc + BEAT) begin
      n_bad++; $display("FAIL single_done_time got=%0d want=%0d", t_done, t_acc + BEAT);
    end
  endtask

  task automatic test_back_to_back();
    longint unsigned acc [3];
    longint unsigned dn [$];
    int unsigned idx = 0;
    bit ok = 1'b0;
    note_valid = 1'b1; note_code = 4'd8; note_beats = 4'd2;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      n_cmp++;
      if ({spk1, note_done, busy, note_ready} !== exp_outs()) begin
        n_bad++;
        $display("FAIL b2b_cycle cyc=%0d got=%b want=%b", cyc, {spk1, note_done, busy, note_ready}, exp_outs());
      end
      if (note_done === 1'b1) dn.push_back(cyc);
      if (m_acc) begin
        acc[idx] = cyc;
        idx++;
        if (idx < 3) note_code = (idx == 2) ? 4'd10 : 4'd8;
        else note_valid = 1'b0;
      end
      if (idx == 3 && !m_active && !m_pend) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL b2b_timeout cyc=%0d", cyc); end
    n_cmp++;
    if (acc[1] != acc[0] + 2) begin
      n_bad++; $display("FAIL b2b_second_accept got=%0d want=%0d", acc[1], acc[0] + 2);
    end
    n_cmp++;
    if (acc[2] != acc[0] + 2 * BEAT + 2) begin
      n_bad++; $display("FAIL b2b_third_accept got=%0d want=%0d", acc[2], acc[0] + 2 * BEAT + 2);
    end
    n_cmp++;
    if (dn.size() != 3) begin
      n_bad++; $display("FAIL b2b_done_count got=%0d want=3", dn.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_cmp++;
        if (dn[j] != acc[0] + longint'(j + 1) * 2 * BEAT) begin
          n_bad++; $display("FAIL b2b_done_time idx=%0d got=%0d want=%0d", j, dn[j], acc[0] + longint'(j + 1) * 2 * BEAT);
        end
      end
    end
  endtask

  task automatic test_rest();
    longint unsigned t_acc = 0;
    longint unsigned t_done = 0;
    int unsigned n_done = 0;
    int unsigned n_spk = 0;
    int unsigned n_idle = 0;
    bit ok = 1'b0;
    note_valid = 1'b1; note_code = 4'd0; note_beats = 4'd3;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      n_cmp++;
      if ({spk1, note_done, busy, note_ready} !== exp_outs()) begin
        n_bad++;
        $display("FAIL rest_cycle cyc=%0d got=%b want=%b", cyc, {spk1, note_done, busy, note_ready}, exp_outs());
      end
      if (m_acc) begin t_acc = cyc; note_valid = 1'b0; end
      if (spk1 !== 1'b0) n_spk++;
      if (note_done === 1'b1) begin n_done++; t_done = cyc; end
      if (t_acc != 0 && t_done == 0 && busy !== 1'b1) n_idle++;
      if (t_acc != 0 && !m_active && !m_pend) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL rest_timeout cyc=%0d", cyc); end
    n_cmp++;
    if (n_spk != 0) begin n_bad++; $display("FAIL rest_spk_high got=%0d want=0", n_spk); end
    n_cmp++;
    if (n_done != 1) begin n_bad++; $display("FAIL rest_done_count got=%0d want=1", n_done); end
    n_cmp++;
    if (n_idle != 0) begin n_bad++; $display("FAIL rest_busy_drop got=%0d want=0", n_idle); end
    n_cmp++;
    if (t_done != t_acc + 3 * BEAT) begin
      n_bad++; $display("FAIL rest_done_time got=%0d want=%0d", t_done, t_acc + 3 * BEAT);
    end
  endtask

  task automatic test_zero_beats();
    longint unsigned a0 = 0;
    longint unsigned a1 = 0;
    longint unsigned t_done = 0;
    longint unsigned t_rise = 0;
    int unsigned n_done = 0;
    int unsigned idx = 0;
    bit ok = 1'b0;
    note_valid = 1'b1; note_code = 4'd3; note_beats = 4'd0;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      n_cmp++;
      if ({spk1, note_done, busy, note_ready} !== exp_outs()) begin
        n_bad++;
        $display("FAIL zero_cycle cyc=%0d got=%b want=%b", cyc, {spk1, note_done, busy, note_ready}, exp_outs());
      end
      if (m_acc) begin
        if (idx == 0) begin a0 = cyc; note_code = 4'd5; note_beats = 4'd1; end
        else begin a1 = cyc; note_valid = 1'b0; end
        idx++;
      end
      if (note_done === 1'b1) begin n_done++; t_done = cyc; end
      if (spk1 === 1'b1 && t_rise == 0) t_rise = cyc;
      if (idx == 2 && !m_active && !m_pend) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL zero_timeout cyc=%0d", cyc); end
    n_cmp++;
    if (a1 != a0 + 2) begin n_bad++; $display("FAIL zero_g4_accept got=%0d want=%0d", a1, a0 + 2); end
    n_cmp++;
    if (n_done != 1) begin n_bad++; $display("FAIL zero_done_count got=%0d want=1", n_done); end
    n_cmp++;
    if (t_done != a1 + BEAT) begin n_bad++; $display("FAIL zero_done_time got=%0d want=%0d", t_done, a1 + BEAT); end
    n_cmp++;
    if (t_rise != a1 + 1 + hp_ref(4'd5)) begin
      n_bad++; $display("FAIL zero_first_toggle got=%0d want=%0d", t_rise, a1 + 1 + hp_ref(4'd5));
    end
  endtask

  task automatic test_reset_mid();
    longint unsigned a0 = 0;
    int unsigned idx = 0;
    bit ok = 1'b0;
    note_valid = 1'b1; note_code = 4'd6; note_beats = 4'd2;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      n_cmp++;
      if ({spk1, note_done, busy, note_ready} !== exp_outs()) begin
        n_bad++;
        $display("FAIL midrst_cycle cyc=%0d got=%b want=%b", cyc, {spk1, note_done, busy, note_ready}, exp_outs());
      end
      if (m_acc) begin
        if (idx == 0) begin a0 = cyc; note_code = 4'd1; note_beats = 4'd1; end
        else note_valid = 1'b0;
        idx++;
      end
      if (idx == 2 && cyc >= a0 + 1300) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL midrst_timeout cyc=%0d", cyc); end
    n_cmp++;
    if (spk1 !== 1'b1 || busy !== 1'b1 || note_ready !== 1'b0) begin
      n_bad++; $display("FAIL midrst_pre got=%b want=110", {spk1, busy, note_ready});
    end
    note_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    n_cmp++;
    if ({spk1, busy, note_ready} !== 3'b001) begin
      n_bad++; $display("FAIL midrst_after got=%b want=001", {spk1, busy, note_ready});
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      n_cmp++;
      if ({spk1, note_done, busy, note_ready} !== exp_outs()) begin
        n_bad++;
        $display("FAIL midrst_idle cyc=%0d got=%b want=%b", cyc, {spk1, note_done, busy, note_ready}, exp_outs());
      end
    end
  endtask

  task automatic test_random();
    int unsigned gap;
    bit ok;
    for (int n = 0; n < 6; n++) begin
      gap = $urandom_range(0, 300);
      note_valid = 1'b0;
      for (int g = 0; g < int'(gap); g++) begin
        tick();
        n_cmp++;
        if ({spk1, note_done, busy, note_ready} !== exp_outs()) begin
          n_bad++;
          $display("FAIL random_cycle cyc=%0d got=%b want=%b", cyc, {spk1, note_done, busy, note_ready}, exp_outs());
        end
      end
      note_code = 4'($urandom_range(0, 15));
      note_beats = 4'($urandom_range(0, 2));
      note_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < LIMIT; i++) begin
        tick();
        n_cmp++;
        if ({spk1, note_done, busy, note_ready} !== exp_outs()) begin
          n_bad++;
          $display("FAIL random_cycle cyc=%0d got=%b want=%b", cyc, {spk1, note_done, busy, note_ready}, exp_outs());
        end
        if (m_acc) begin ok = 1'b1; break; end
      end
      if (!ok) begin n_cmp++; n_bad++; $display("FAIL random_accept_timeout cyc=%0d", cyc); end
    end
    note_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      n_cmp++;
      if ({spk1, note_done, busy, note_ready} !== exp_outs()) begin
        n_bad++;
        $display("FAIL random_drain cyc=%0d got=%b want=%b", cyc, {spk1, note_done, busy, note_ready}, exp_outs());
      end
      if (!m_active && !m_pend) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL random_drain_timeout cyc=%0d", cyc); end
  endtask

  initial begin
    rst_n = 1'b0; note_valid = 1'b0; note_code = '0; note_beats = '0;
    test_reset();
    test_single_a4();
    test_back_to_back();
    test_rest();
    test_zero_beats();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
